// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// One access per two cycles: IDLE arbitrates and latches, ISSUE drives the RAM.
module mem_arbiter #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] rdata,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t        state, state_d;
  logic          last, last_d;
  logic          owner, owner_d;
  logic          pick1;
  logic          gnt0_d, gnt1_d, rvalid0_d, rvalid1_d;
  logic          ram_en_d, ram_we_d;
  logic [AW-1:0] ram_addr_d;
  logic [DW-1:0] ram_wdata_d;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d     = state;
    last_d      = last;
    owner_d     = owner;
    pick1       = 1'b0;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr;
    ram_wdata_d = ram_wdata;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester not granted last wins.
          pick1       = req1 && (!req0 || !last);
          owner_d     = pick1;
          last_d      = pick1;
          state_d     = ISSUE;
          ram_en_d    = 1'b1;
          ram_we_d    = pick1 ? we1 : we0;
          ram_addr_d  = pick1 ? addr1 : addr0;
          ram_wdata_d = pick1 ? wdata1 : wdata0;
          gnt0_d      = !pick1;
          gnt1_d      = pick1;
        end
      end
      ISSUE: begin
        state_d = IDLE;
        // RAM presents read data in the cycle after the strobe.
        if (!ram_we) begin
          rvalid0_d = !owner;
          rvalid1_d = owner;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      state     <= state_d;
      last      <= last_d;
      owner     <= owner_d;
      gnt0      <= gnt0_d;
      gnt1      <= gnt1_d;
      rvalid0   <= rvalid0_d;
      rvalid1   <= rvalid1_d;
      ram_en    <= ram_en_d;
      ram_we    <= ram_we_d;
      ram_addr  <= ram_addr_d;
      ram_wdata <= ram_wdata_d;
    end
  end

  // Read data is forwarded from the RAM in the rvalid cycle, zero otherwise.
  assign rdata = (rvalid0 || rvalid1) ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences,
// and a randomized run checked against a transaction-level memory model.
module tb_mem_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, ram_en, ram_we;
  logic [DW-1:0] rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ram     [32];
  logic [DW-1:0] ref_mem [32];

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rdata(rdata),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Synchronous single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr[4:0]] <= ram_wdata;
      else        ram_rdata <= ram[ram_addr[4:0]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
  endtask

  task automatic init_mem();
    for (int i = 0; i < 32; i++) begin
      ram[i]     = DW'(i * 32'h1111);
      ref_mem[i] = DW'(i * 32'h1111);
    end
    ram[16]     = 16'hBEEF;
    ref_mem[16] = 16'hBEEF;
  endtask

  task automatic do_reset(input bit check_values);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    if (check_values) begin
      chk("rst_gnt0", 32'(gnt0), 32'(0));
      chk("rst_gnt1", 32'(gnt1), 32'(0));
      chk("rst_rvalid0", 32'(rvalid0), 32'(0));
      chk("rst_rvalid1", 32'(rvalid1), 32'(0));
      chk("rst_ram_en", 32'(ram_en), 32'(0));
      chk("rst_ram_we", 32'(ram_we), 32'(0));
      chk("rst_ram_addr", 32'(ram_addr), 32'(0));
      chk("rst_ram_wdata", 32'(ram_wdata), 32'(0));
      chk("rst_rdata", 32'(rdata), 32'(0));
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int r0, w0, a0, d0, r1, w1, a1, d1;
    int g0, g1, en, we, addr, wd, v0, v1, rd;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [1:0]    pend, wr, exp_rv;
    logic [AW-1:0] a_r [2];
    logic [DW-1:0] d_r [2];
    logic [DW-1:0] exp_rd [2];
    int            wait_cnt [2];
    logic [1:0]    g;

    idle_inputs();
    init_mem();
    #2;
    do_reset(1'b1);

    // r0 w0 a0 d0 | r1 w1 a1 d1 | g0 g1 en we addr wd | v0 v1 rd
    tbl[0]  = '{1, 0, 'h10, 0,  0, 0, 0, 0,          1, 0, 1, 0, 'h10, 0,       0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0,     0, 0, 0, 0,          0, 0, 0, 0, 'h10, 0,       1, 0, 'hBEEF};
    tbl[2]  = '{0, 0, 0, 0,     1, 1, 'h4, 'h1234,   0, 1, 1, 1, 'h4, 'h1234,   0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0,     0, 0, 0, 0,          0, 0, 0, 0, 'h4, 'h1234,   0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0,     1, 0, 'h4, 0,        0, 1, 1, 0, 'h4, 0,        0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0,     0, 0, 0, 0,          0, 0, 0, 0, 'h4, 0,        0, 1, 'h1234};
    tbl[6]  = '{1, 0, 'h1, 0,   1, 0, 'h2, 0,        1, 0, 1, 0, 'h1, 0,        0, 0, 0};
    tbl[7]  = '{0, 0, 0, 0,     1, 0, 'h2, 0,        0, 0, 0, 0, 'h1, 0,        1, 0, 'h1111};
    tbl[8]  = '{0, 0, 0, 0,     1, 0, 'h2, 0,        0, 1, 1, 0, 'h2, 0,        0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0,     0, 0, 0, 0,          0, 0, 0, 0, 'h2, 0,        0, 1, 'h2222};
    tbl[10] = '{1, 0, 'h3, 0,   1, 0, 'h5, 0,        1, 0, 1, 0, 'h3, 0,        0, 0, 0};
    tbl[11] = '{0, 0, 0, 0,     0, 0, 0, 0,          0, 0, 0, 0, 'h3, 0,        1, 0, 'h3333};
    tbl[12] = '{0, 0, 0, 0,     0, 0, 0, 0,          0, 0, 0, 0, 'h3, 0,        0, 0, 0};

    foreach (tbl[i]) begin
      req0 = 1'(tbl[i].r0); we0 = 1'(tbl[i].w0); addr0 = AW'(tbl[i].a0); wdata0 = DW'(tbl[i].d0);
      req1 = 1'(tbl[i].r1); we1 = 1'(tbl[i].w1); addr1 = AW'(tbl[i].a1); wdata1 = DW'(tbl[i].d1);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_gnt0", i), 32'(gnt0), 32'(tbl[i].g0));
      chk($sformatf("vec%0d_gnt1", i), 32'(gnt1), 32'(tbl[i].g1));
      chk($sformatf("vec%0d_ram_en", i), 32'(ram_en), 32'(tbl[i].en));
      chk($sformatf("vec%0d_ram_we", i), 32'(ram_we), 32'(tbl[i].we));
      chk($sformatf("vec%0d_ram_addr", i), 32'(ram_addr), 32'(tbl[i].addr));
      chk($sformatf("vec%0d_ram_wdata", i), 32'(ram_wdata), 32'(tbl[i].wd));
      chk($sformatf("vec%0d_rvalid0", i), 32'(rvalid0), 32'(tbl[i].v0));
      chk($sformatf("vec%0d_rvalid1", i), 32'(rvalid1), 32'(tbl[i].v1));
      if (tbl[i].v0 != 0 || tbl[i].v1 != 0)
        chk($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(tbl[i].rd));
    end

    // Contention from reset: both held, grants alternate starting with requester 0.
    do_reset(1'b0);
    req0 = 1'b1; addr0 = 16'h1; req1 = 1'b1; addr1 = 16'h2;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk($sformatf("cont%0d_gnt0", c), 32'(gnt0), 32'((c % 4) == 0));
      chk($sformatf("cont%0d_gnt1", c), 32'(gnt1), 32'((c % 4) == 2));
    end

    // Back-to-back writes from requester 0 alone: one grant every two cycles.
    do_reset(1'b0);
    init_mem();
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h7; wdata0 = 16'h5A5A;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b%0d_gnt0", c), 32'(gnt0), 32'((c % 2) == 0));
      chk($sformatf("b2b%0d_gnt1", c), 32'(gnt1), 32'(0));
      chk($sformatf("b2b%0d_rvalid0", c), 32'(rvalid0), 32'(0));
    end

    // Reset asserted during a read ISSUE cycle discards the access.
    do_reset(1'b0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h10;
    @(posedge clk); #1;
    chk("rsti_gnt0", 32'(gnt0), 32'(1));
    chk("rsti_ram_en", 32'(ram_en), 32'(1));
    req0 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rsti_ram_en_low", 32'(ram_en), 32'(0));
    chk("rsti_gnt0_low", 32'(gnt0), 32'(0));
    chk("rsti_rvalid0_low", 32'(rvalid0), 32'(0));
    chk("rsti_ram_addr_low", 32'(ram_addr), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("rsti%0d_rvalid0", c), 32'(rvalid0), 32'(0));
      chk($sformatf("rsti%0d_ram_en", c), 32'(ram_en), 32'(0));
    end

    // Randomized traffic against a transaction-level model.
    do_reset(1'b0);
    init_mem();
    pend = '0; wr = '0; exp_rv = '0;
    for (int i = 0; i < 2; i++) begin
      a_r[i] = '0; d_r[i] = '0; exp_rd[i] = '0; wait_cnt[i] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      g = {gnt1, gnt0};
      chk("rnd_gnt_excl", 32'(gnt0 && gnt1), 32'(0));
      chk("rnd_rvalid_excl", 32'(rvalid0 && rvalid1), 32'(0));
      chk("rnd_rvalid0", 32'(rvalid0), 32'(exp_rv[0]));
      chk("rnd_rvalid1", 32'(rvalid1), 32'(exp_rv[1]));
      for (int i = 0; i < 2; i++)
        if (exp_rv[i]) chk($sformatf("rnd_rdata%0d", i), 32'(rdata), 32'(exp_rd[i]));
      exp_rv = '0;
      chk("rnd_ram_en", 32'(ram_en), 32'(g != 2'b00));
      for (int i = 0; i < 2; i++) begin
        if (g[i]) begin
          chk($sformatf("rnd_gnt%0d_requested", i), 32'(pend[i]), 32'(1));
          chk($sformatf("rnd_addr%0d", i), 32'(ram_addr), 32'(a_r[i]));
          chk($sformatf("rnd_we%0d", i), 32'(ram_we), 32'(wr[i]));
          if (wr[i]) begin
            chk($sformatf("rnd_wdata%0d", i), 32'(ram_wdata), 32'(d_r[i]));
            ref_mem[a_r[i][4:0]] = d_r[i];
          end else begin
            exp_rv[i] = 1'b1;
            exp_rd[i] = ref_mem[a_r[i][4:0]];
          end
          pend[i] = 1'b0;
        end else if (pend[i]) begin
          wait_cnt[i]++;
          chk($sformatf("rnd_starve%0d", i), 32'(wait_cnt[i] > 3), 32'(0));
          if ($urandom_range(15) == 0) pend[i] = 1'b0;
        end
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i]     = 1'b1;
          wr[i]       = 1'($urandom_range(1));
          a_r[i]      = AW'($urandom_range(31));
          d_r[i]      = DW'($urandom);
          wait_cnt[i] = 0;
        end
      end
      req0 = pend[0]; we0 = wr[0]; addr0 = a_r[0]; wdata0 = d_r[0];
      req1 = pend[1]; we1 = wr[1]; addr1 = a_r[1]; wdata1 = d_r[1];
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
